// File: rtl/axi_read_fill_pkg.sv
// -----------------------------------------------------------------------------
// axi_read_fill_pkg
// Shared definitions for the cache-side AXI engines (read fill, write buffer).
//   - AXI encodings: burst type, transfer size, response codes
//   - Read-fill FSM state encoding
//   - Line geometry helpers derived from offset_width (log2 words per line)
// -----------------------------------------------------------------------------
package axi_read_fill_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_AR     = 3'd2,
    ST_R      = 3'd3,
    ST_DONE   = 3'd4
  } rf_state_e;

  // 32-bit words per line.
  function automatic int beats_f(input int ow);
    return 1 << ow;
  endfunction

  // Line width in bits.
  function automatic int line_f(input int ow);
    return (1 << ow) * 32;
  endfunction

  // Any response whose top bit is set (SLVERR/DECERR) is an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return !(resp == RESP_OKAY || resp == RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/axi_read_fill.sv
// -----------------------------------------------------------------------------
// axi_read_fill
// Cache-line read engine sitting between the cache miss path and AXI AR/R.
// One request at a time: cached requests first ask the write buffer for the
// line (a hit short-circuits memory), otherwise a single INCR burst fetches
// the line; uncached requests wait for the write buffer to drain and then
// fetch one word.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_addr/uncached/valid   request in; req_ready high only when idle
//   resp_data/valid/error     assembled line, 1-cycle completion pulse, error
//   query_addr/ok/data        write buffer lookup (line aligned)
//   wb_empty                  write buffer drained (gates uncached reads)
//   ar*                       AXI read address channel (master)
//   r*                        AXI read data channel (master)
// -----------------------------------------------------------------------------
module axi_read_fill
  import axi_read_fill_pkg::*;
#(
  parameter int offset_width = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       req_addr,
  input  logic                              req_uncached,
  input  logic                              req_valid,
  output logic                              req_ready,
  output logic [(32<<offset_width)-1:0]     resp_data,
  output logic                              resp_valid,
  output logic                              resp_error,
  output logic [31:0]                       query_addr,
  input  logic                              query_ok,
  input  logic [(32<<offset_width)-1:0]     query_data,
  input  logic                              wb_empty,
  output logic [31:0]                       araddr,
  output logic [7:0]                        arlen,
  output logic [2:0]                        arsize,
  output logic [1:0]                        arburst,
  output logic                              arvalid,
  input  logic                              arready,
  input  logic [31:0]                       rdata,
  input  logic [1:0]                        rresp,
  input  logic                              rlast,
  input  logic                              rvalid,
  output logic                              rready
);

  localparam int BEATS = beats_f(offset_width);
  localparam int LINE  = line_f(offset_width);

  rf_state_e                 state_q, state_d;
  logic [31:0]               addr_q,  addr_d;
  logic                      unc_q,   unc_d;
  logic [LINE-1:0]           line_q,  line_d;
  logic [offset_width-1:0]   cnt_q,   cnt_d;
  logic                      err_q,   err_d;

  // Byte offset within a word never matters: words are fetched whole.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        // Uncached device reads must not overtake buffered device writes.
        if (unc_q)         state_d = wb_empty ? ST_AR : ST_LOOKUP;
        else if (query_ok) state_d = ST_DONE;
        else               state_d = ST_AR;
      end
      ST_AR:     if (arready) state_d = ST_R;
      ST_R:      if (rvalid && rlast) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: every handshake output is a pure function of state, so the
  // AR address/controls are held stable from registers while arready is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    query_addr = '0;
    araddr     = '0;
    arlen      = '0;
    arsize     = '0;
    arburst    = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    unique case (state_q)
      ST_IDLE:   req_ready = 1'b1;
      ST_LOOKUP: query_addr = unc_q ? 32'd0 : addr_q;
      ST_AR: begin
        arvalid = 1'b1;
        araddr  = addr_q;
        arlen   = unc_q ? 8'd0 : 8'(BEATS - 1);
        arsize  = SIZE_4B;
        arburst = BURST_INCR;
      end
      ST_R:      rready = 1'b1;
      ST_DONE:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_data  = line_q;
  assign resp_error = err_q;

  // ---------------------------------------------------------------------------
  // Request / line datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d = addr_q;
    unc_d  = unc_q;
    line_d = line_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_uncached ? {req_addr[31:2], 2'b00}
                                : {req_addr[31:offset_width+2], {(offset_width+2){1'b0}}};
          unc_d  = req_uncached;
          line_d = '0;
          cnt_d  = '0;
          err_d  = 1'b0;
        end
      end
      ST_LOOKUP: begin
        if (!unc_q && query_ok) line_d = query_data;
      end
      ST_R: begin
        if (rvalid) begin
          line_d[{cnt_q, 5'd0} +: 32] = rdata;
          // Counter parks on the last word: surplus beats overwrite it.
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          err_d = err_q | resp_is_err(rresp);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      unc_q  <= 1'b0;
      line_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      unc_q  <= unc_d;
      line_q <= line_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_fill.sv
// -----------------------------------------------------------------------------
// tb_axi_read_fill
// Scripted requester + AXI slave + write-buffer stub. The driver walks each
// transaction cycle by cycle and publishes what the outputs must be in each
// cycle (m_* flags and the expected line); one compare process checks every
// output on every falling edge against those expectations.
// -----------------------------------------------------------------------------
module tb_axi_read_fill;
  import axi_read_fill_pkg::*;

  localparam int OW    = 3;
  localparam int BEATS = 1 << OW;
  localparam int LINE  = BEATS * 32;

  logic            clk;
  logic            rst;
  logic [31:0]     req_addr;
  logic            req_uncached;
  logic            req_valid;
  logic            req_ready;
  logic [LINE-1:0] resp_data;
  logic            resp_valid;
  logic            resp_error;
  logic [31:0]     query_addr;
  logic            query_ok;
  logic [LINE-1:0] query_data;
  logic            wb_empty;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  axi_read_fill #(.offset_width(OW)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_uncached(req_uncached), .req_valid(req_valid),
    .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_error(resp_error),
    .query_addr(query_addr), .query_ok(query_ok), .query_data(query_data),
    .wb_empty(wb_empty),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural expectations for the current cycle.
  bit              m_idle, m_exp_resp, m_exp_ar, m_in_r, m_inlk, m_unc, m_err;
  logic [31:0]     m_araddr, m_qaddr;
  logic [LINE-1:0] m_line;
  // Hand-computed literals for the directed cases.
  bit              lit_en, lit_err;
  logic [31:0]     lit_araddr;
  logic [LINE-1:0] lit_line;

  int checks, errors;

  task automatic cmp(input string nm, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp("req_ready",  LINE'(req_ready),  LINE'(m_idle));
      cmp("resp_valid", LINE'(resp_valid), LINE'(m_exp_resp));
      cmp("arvalid",    LINE'(arvalid),    LINE'(m_exp_ar));
      cmp("rready",     LINE'(rready),     LINE'(m_in_r));
      cmp("query_addr", LINE'(query_addr), LINE'(m_inlk ? m_qaddr : 32'd0));
      cmp("araddr",     LINE'(araddr),     LINE'(m_exp_ar ? m_araddr : 32'd0));
      cmp("arlen",      LINE'(arlen),      LINE'(m_exp_ar ? (m_unc ? 8'd0 : 8'(BEATS-1)) : 8'd0));
      cmp("arsize",     LINE'(arsize),     LINE'(m_exp_ar ? 3'b010 : 3'b000));
      cmp("arburst",    LINE'(arburst),    LINE'(m_exp_ar ? 2'b01 : 2'b00));
      if (m_idle || m_exp_resp) begin
        cmp("resp_data",  resp_data,        m_line);
        cmp("resp_error", LINE'(resp_error), LINE'(m_err));
      end
      if (lit_en && m_exp_ar) cmp("lit_araddr", LINE'(araddr), LINE'(lit_araddr));
      if (lit_en && m_exp_resp) begin
        cmp("lit_line", resp_data,         lit_line);
        cmp("lit_err",  LINE'(resp_error), LINE'(lit_err));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_idle = 1'b1; m_exp_resp = 1'b0; m_exp_ar = 1'b0; m_in_r = 1'b0;
    m_inlk = 1'b0; m_unc = 1'b0; m_err = 1'b0; m_line = '0;
    m_araddr = '0; m_qaddr = '0;
  endtask

  // One complete transaction. base!=0 gives beat data base+i, else random.
  // errbeat: beat index forced to SLVERR, -1 none, -2 random responses.
  // rst_after: pulse reset just before that beat index (-1 never).
  task automatic do_req(input logic [31:0] addr, input bit unc, input bit hit,
                        input logic [LINE-1:0] pat, input int nb, input int ard,
                        input int gapmax, input int errbeat, input int wbd,
                        input logic [31:0] base, input int rst_after);
    logic [31:0] d;
    logic [1:0]  rr;
    int          idx;
    req_addr = addr; req_uncached = unc; req_valid = 1'b1;
    query_ok = hit;  query_data = pat;
    wb_empty = (wbd == 0);
    tick;                                   // accept edge
    req_valid = 1'b0;
    req_addr  = $urandom;                   // engine must have latched it
    m_idle = 1'b0; m_inlk = 1'b1; m_unc = unc;
    m_qaddr  = addr & ~32'(BEATS*4 - 1);
    m_araddr = unc ? (addr & ~32'h3) : (addr & ~32'(BEATS*4 - 1));
    if (unc) m_qaddr = '0;
    m_line = '0; m_err = 1'b0;
    if (!unc && hit) begin
      m_line = pat;
      tick;                                 // LOOKUP -> DONE
      m_inlk = 1'b0; m_exp_resp = 1'b1;
      tick;
      m_exp_resp = 1'b0; m_idle = 1'b1; query_ok = 1'b0;
      return;
    end
    if (unc && wbd > 0) begin
      repeat (wbd) tick;
      wb_empty = 1'b1;
    end
    tick;                                   // -> AR
    m_inlk = 1'b0; m_exp_ar = 1'b1; query_ok = 1'b0;
    repeat (ard) tick;
    arready = 1'b1;
    tick;                                   // AR handshake -> R
    arready = 1'b0; m_exp_ar = 1'b0; m_in_r = 1'b1;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(gapmax, 0)) tick;
      if (rst_after == i) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        return;
      end
      d = (base != 0) ? base + 32'(i) : $urandom;
      if (errbeat == i)       rr = 2'b10;
      else if (errbeat == -2) rr = ($urandom_range(15, 0) == 0) ? 2'($urandom_range(3, 2))
                                                               : 2'($urandom_range(1, 0));
      else                    rr = 2'b00;
      rvalid = 1'b1; rdata = d; rresp = rr; rlast = (i == nb - 1);
      tick;
      rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0;
      idx = (i < BEATS) ? i : BEATS - 1;
      m_line[idx*32 +: 32] = d;
      m_err = m_err | rr[1];
    end
    m_in_r = 1'b0; m_exp_resp = 1'b1;
    tick;
    m_exp_resp = 1'b0; m_idle = 1'b1; wb_empty = 1'b1;
  endtask

  initial begin
    logic [31:0]     a;
    logic [LINE-1:0] p;
    bit              u, h;
    int              nb, r;

    checks = 0; errors = 0;
    lit_en = 1'b0; lit_err = 1'b0; lit_araddr = '0; lit_line = '0;
    model_reset();
    req_addr = '0; req_uncached = 1'b0; req_valid = 1'b0;
    query_ok = 1'b0; query_data = '0; wb_empty = 1'b1;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;                                   // idle cycle: reset values checked

    // Cached miss, sequential data.
    lit_en = 1'b1; lit_err = 1'b0; lit_araddr = 32'h1000_0040;
    lit_line = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    do_req(32'h1000_0044, 1'b0, 1'b0, '0, 8, 0, 0, -1, 0, 32'hA0, -1);

    // Write buffer hit: no AR, response at T+2.
    lit_line = 256'h0011223344556677_8899AABBCCDDEEFF_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    lit_err  = 1'b0;
    do_req(32'h2000_0104, 1'b0, 1'b1, lit_line, 0, 0, 0, -1, 0, 32'h0, -1);

    // Uncached behind 5 cycles of pending writes; query_ok asserted but ignored.
    lit_araddr = 32'h1FE0_0008; lit_err = 1'b0;
    lit_line   = {224'h0, 32'hDEAD_BEEF};
    do_req(32'h1FE0_0008, 1'b1, 1'b1, '1, 1, 0, 0, -1, 5, 32'hDEAD_BEEF, -1);

    // Slow arready, gaps between beats, SLVERR on beat 3.
    lit_araddr = 32'h3000_0020; lit_err = 1'b1;
    lit_line   = {32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100};
    do_req(32'h3000_003C, 1'b0, 1'b0, '0, 8, 4, 2, 3, 0, 32'h100, -1);
    lit_en = 1'b0;

    // Reset after 3 beats, then a clean request.
    do_req(32'h4000_0080, 1'b0, 1'b0, '0, 8, 1, 1, -1, 0, 32'h0, 3);
    tick;
    do_req(32'h4000_0080, 1'b0, 1'b0, '0, 8, 1, 1, -1, 0, 32'h0, -1);

    // Early rlast and surplus beats.
    do_req(32'h5000_0000, 1'b0, 1'b0, '0, 3, 0, 0, -1, 0, 32'h0, -1);
    do_req(32'h5000_0020, 1'b0, 1'b0, '0, BEATS + 2, 0, 0, -1, 0, 32'h0, -1);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      u = ($urandom_range(3, 0) == 0);
      h = u ? 1'($urandom_range(1, 0)) : ($urandom_range(2, 0) == 0);
      for (int w = 0; w < BEATS; w++) p[w*32 +: 32] = $urandom;
      r = $urandom_range(5, 0);
      if (u)           nb = 1;
      else if (r == 0) nb = $urandom_range(BEATS - 1, 1);
      else if (r == 1) nb = BEATS + $urandom_range(2, 1);
      else             nb = BEATS;
      do_req(a, u, h, p, nb, $urandom_range(3, 0), $urandom_range(2, 0), -2,
             u ? $urandom_range(3, 0) : 0, 32'h0, -1);
      repeat ($urandom_range(2, 0)) tick;
    end

    tick; tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
